// File: rtl/io_delay_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_delay_array: N-channel programmable fabric delay with tap sweep       |
// | Rev 1.0 - initial parametrised release                                   |
// +--------------------------------------------------------------------------+
module io_delay_array #(
  parameter int CH_NUM    = 4,
  parameter int TAP_WIDTH = 5,
  parameter int SWEEP_DIV = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CH_NUM-1:0]           di,
  output logic [CH_NUM-1:0]           o_do,
  input  logic [CH_NUM-1:0]           ldcnt,
  input  logic [CH_NUM*TAP_WIDTH-1:0] dicnt,
  output logic [CH_NUM*TAP_WIDTH-1:0] docnt,
  input  logic                        sweep_en,
  output logic                        sweep_wrap,
  output logic                        rdy
);

  localparam int DEPTH = 2**TAP_WIDTH;
  localparam int DIV_W = $clog2(SWEEP_DIV);
  localparam logic [TAP_WIDTH-1:0] c_tap_max  = '1;
  localparam logic [DIV_W-1:0]     c_div_last = DIV_W'(SWEEP_DIV - 1);

  typedef enum logic [0:0] {INIT  = 1'b0, READY = 1'b1} init_state_t;
  typedef enum logic [0:0] {IDLE  = 1'b0, RUN   = 1'b1} sweep_state_t;

  logic [DEPTH-1:0]     sr_q  [CH_NUM];
  logic [DEPTH-1:0]     sr_d  [CH_NUM];
  logic [TAP_WIDTH-1:0] tap_q [CH_NUM];
  logic [TAP_WIDTH-1:0] tap_d [CH_NUM];
  logic [CH_NUM-1:0]    do_q, do_d;
  logic [CH_NUM-1:0]    ld_s1_q, ld_s2_q, ld_s3_q, ld_edge_q, ld_edge_d;
  logic                 sw_s1_q, sw_s1_d, sw_s2_q;
  init_state_t          init_q, init_d;
  logic [TAP_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                 rdy_q, rdy_d;
  sweep_state_t         sweep_q, sweep_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 wrap_q, wrap_d;
  logic                 step;

  always_comb begin
    step      = (sweep_q == RUN) && (div_q == c_div_last);
    ld_edge_d = ld_s2_q & ~ld_s3_q;
    // Sweep enable is only sampled once the lines are flushed.
    sw_s1_d   = sweep_en & rdy_q;

    for (int k = 0; k < CH_NUM; k++) begin
      sr_d[k] = {sr_q[k][DEPTH-2:0], di[k]};
      do_d[k] = (init_q == READY) ? sr_q[k][tap_q[k]] : 1'b0;
      // A load edge overrides a coincident sweep step on the same channel.
      if (ld_edge_q[k])
        tap_d[k] = dicnt[k*TAP_WIDTH +: TAP_WIDTH];
      else if (step)
        tap_d[k] = tap_q[k] + TAP_WIDTH'(1);
      else
        tap_d[k] = tap_q[k];
    end
    wrap_d = step && (tap_q[0] == c_tap_max) && !ld_edge_q[0];

    init_d     = init_q;
    init_cnt_d = init_cnt_q;
    rdy_d      = rdy_q;
    if (init_q == INIT) begin
      init_cnt_d = init_cnt_q + TAP_WIDTH'(1);
      if (init_cnt_q == c_tap_max) begin
        init_d = READY;
        rdy_d  = 1'b1;
      end
    end

    sweep_d = sweep_q;
    div_d   = div_q;
    case (sweep_q)
      IDLE: begin
        div_d = '0;
        if (sw_s2_q && rdy_q) sweep_d = RUN;
      end
      RUN: begin
        if (!sw_s2_q) begin
          sweep_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = (div_q == c_div_last) ? '0 : div_q + DIV_W'(1);
        end
      end
      default: begin
        sweep_d = IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH_NUM; k++) begin
        sr_q[k]  <= '0;
        tap_q[k] <= '0;
      end
      do_q       <= '0;
      ld_s1_q    <= '0;
      ld_s2_q    <= '0;
      ld_s3_q    <= '0;
      ld_edge_q  <= '0;
      sw_s1_q    <= 1'b0;
      sw_s2_q    <= 1'b0;
      init_q     <= INIT;
      init_cnt_q <= '0;
      rdy_q      <= 1'b0;
      sweep_q    <= IDLE;
      div_q      <= '0;
      wrap_q     <= 1'b0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        sr_q[k]  <= sr_d[k];
        tap_q[k] <= tap_d[k];
      end
      do_q       <= do_d;
      ld_s1_q    <= ldcnt;
      ld_s2_q    <= ld_s1_q;
      ld_s3_q    <= ld_s2_q;
      ld_edge_q  <= ld_edge_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s1_q;
      init_q     <= init_d;
      init_cnt_q <= init_cnt_d;
      rdy_q      <= rdy_d;
      sweep_q    <= sweep_d;
      div_q      <= div_d;
      wrap_q     <= wrap_d;
    end
  end

  generate
    for (genvar k = 0; k < CH_NUM; k++) begin : g_docnt
      assign docnt[k*TAP_WIDTH +: TAP_WIDTH] = tap_q[k];
    end
  endgenerate

  assign o_do       = do_q;
  assign sweep_wrap = wrap_q;
  assign rdy        = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_io_delay_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_io_delay_array: directed self-checking bench for io_delay_array       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_io_delay_array;

  localparam int CH_NUM    = 4;
  localparam int TAP_WIDTH = 5;
  localparam int SWEEP_DIV = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [CH_NUM-1:0]           di;
  logic [CH_NUM-1:0]           o_do;
  logic [CH_NUM-1:0]           ldcnt;
  logic [CH_NUM*TAP_WIDTH-1:0] dicnt;
  logic [CH_NUM*TAP_WIDTH-1:0] docnt;
  logic                        sweep_en;
  logic                        sweep_wrap;
  logic                        rdy;

  int n_cmp = 0;
  int n_err = 0;

  io_delay_array #(
    .CH_NUM   (CH_NUM),
    .TAP_WIDTH(TAP_WIDTH),
    .SWEEP_DIV(SWEEP_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .di        (di),
    .o_do      (o_do),
    .ldcnt     (ldcnt),
    .dicnt     (dicnt),
    .docnt     (docnt),
    .sweep_en  (sweep_en),
    .sweep_wrap(sweep_wrap),
    .rdy       (rdy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] field(input int ch);
    return 32'(docnt[ch*TAP_WIDTH +: TAP_WIDTH]);
  endfunction

  // Load via a clean rising edge; docnt follows 3 edges after first high sample.
  task automatic load_tap(input int ch, input logic [TAP_WIDTH-1:0] val);
    dicnt[ch*TAP_WIDTH +: TAP_WIDTH] = val;
    ldcnt[ch] = 1'b1;
    tick(4);
    chk($sformatf("load_ch%0d", ch), field(ch), 32'(val));
    ldcnt[ch] = 1'b0;
    tick(3);
  endtask

  task automatic pulse_check(input int ch, input int delay);
    di = CH_NUM'(1) << ch;
    tick(1);
    di = '0;
    tick(delay - 1);
    chk($sformatf("dly_ch%0d_before", ch), 32'(o_do), 32'h0);
    tick(1);
    chk($sformatf("dly_ch%0d_hit", ch), 32'(o_do), 32'(CH_NUM'(1) << ch));
    tick(1);
    chk($sformatf("dly_ch%0d_after", ch), 32'(o_do), 32'h0);
  endtask

  initial begin
    rst      = 1'b0;
    di       = 4'hF;
    ldcnt    = '0;
    dicnt    = '0;
    sweep_en = 1'b0;
    tick(3);
    chk("rst_do",    32'(o_do),       32'h0);
    chk("rst_docnt", 32'(docnt),      32'h0);
    chk("rst_rdy",   32'(rdy),        32'h0);
    chk("rst_wrap",  32'(sweep_wrap), 32'h0);

    rst = 1'b1;
    tick(31);
    chk("init_rdy_low", 32'(rdy),  32'h0);
    chk("init_do_low",  32'(o_do), 32'h0);
    tick(1);
    chk("init_rdy_high", 32'(rdy),  32'h1);
    chk("init_do_still", 32'(o_do), 32'h0);
    tick(1);
    chk("ready_do_tap0", 32'(o_do), 32'hF);

    di = '0;
    tick(40);
    load_tap(1, 5'd7);
    load_tap(3, 5'd31);
    pulse_check(1, 8);
    pulse_check(2, 1);
    pulse_check(3, 32);
    pulse_check(0, 1);

    // Held level ignores dicnt changes; only a fresh rising edge reloads.
    dicnt[2*TAP_WIDTH +: TAP_WIDTH] = 5'd10;
    ldcnt[2] = 1'b1;
    tick(3);
    chk("edge_ch2_pre",  field(2), 32'd0);
    tick(1);
    chk("edge_ch2_load", field(2), 32'd10);
    dicnt[2*TAP_WIDTH +: TAP_WIDTH] = 5'd20;
    tick(6);
    chk("edge_ch2_held", field(2), 32'd10);
    ldcnt[2] = 1'b0;
    tick(4);
    chk("edge_ch2_fall", field(2), 32'd10);
    ldcnt[2] = 1'b1;
    tick(3);
    chk("edge_ch2_pre2", field(2), 32'd10);
    tick(1);
    chk("edge_ch2_new",  field(2), 32'd20);
    ldcnt[2] = 1'b0;
    tick(3);

    dicnt = {4{5'd30}};
    ldcnt = 4'hF;
    tick(4);
    chk("sweep_setup", 32'(docnt), 32'({4{5'd30}}));
    ldcnt = '0;
    tick(3);

    sweep_en = 1'b1;
    tick(6);
    chk("sweep_wait",  32'(docnt),      32'({4{5'd30}}));
    tick(1);
    chk("sweep_31",    32'(docnt),      32'({4{5'd31}}));
    chk("sweep_nowrap",32'(sweep_wrap), 32'h0);
    tick(3);
    chk("sweep_hold31",32'(docnt),      32'({4{5'd31}}));
    tick(1);
    chk("sweep_0",     32'(docnt),      32'h0);
    chk("sweep_wrap",  32'(sweep_wrap), 32'h1);
    sweep_en = 1'b0;
    tick(1);
    chk("wrap_single", 32'(sweep_wrap), 32'h0);
    tick(10);
    chk("sweep_frozen",32'(docnt),      32'h0);

    sweep_en = 1'b1;
    tick(6);
    chk("resweep_wait",32'(docnt), 32'h0);
    tick(1);
    chk("resweep_1",   32'(docnt), 32'({4{5'd1}}));

    // Ch0 load edge lands exactly on the next sweep step.
    dicnt = {5'd30, 5'd30, 5'd30, 5'd5};
    ldcnt[0] = 1'b1;
    tick(3);
    chk("coll_pre",  32'(docnt), 32'({4{5'd1}}));
    tick(1);
    chk("coll_taps", 32'(docnt), 32'({5'd2, 5'd2, 5'd2, 5'd5}));
    chk("coll_wrap", 32'(sweep_wrap), 32'h0);
    ldcnt    = '0;
    sweep_en = 1'b0;
    tick(3);

    sweep_en = 1'b1;
    tick(8);
    rst = 1'b0;
    #1;
    chk("midrst_docnt", 32'(docnt),      32'h0);
    chk("midrst_do",    32'(o_do),       32'h0);
    chk("midrst_rdy",   32'(rdy),        32'h0);
    chk("midrst_wrap",  32'(sweep_wrap), 32'h0);
    tick(2);
    rst = 1'b1;
    tick(31);
    chk("rerdy_low",  32'(rdy), 32'h0);
    tick(1);
    chk("rerdy_high", 32'(rdy), 32'h1);
    tick(6);
    chk("resume_wait", 32'(docnt), 32'h0);
    tick(1);
    chk("resume_step", 32'(docnt), 32'({4{5'd1}}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_delay_array.md
# io_delay_array

Parametrised N-channel fabric delay array; successor to the fixed four-channel tap-load delay block on the 200 MHz IO reference clock. Each channel delays a single-bit input by a programmable number of clock cycles using a fabric shift register. Taps are loaded from GPIO through synchronised load strobes and read back on `docnt`. A new sweep mode steps every tap automatically for delay-scan tests without software intervention.

## Interface

- `CH_NUM`, 4: number of channels (1..16).
- `TAP_WIDTH`, 5: tap field width; `DEPTH = 2**TAP_WIDTH` stages per channel.
- `SWEEP_DIV`, 1024: clock cycles between sweep steps (≥2).

- `clk`, in, 1: IO reference clock; all state on rising edge.
- `rst`, in, 1: asynchronous, active-low reset; deassertion is synchronous to `clk` upstream.
- `di`, in, `CH_NUM`: channel data inputs, synchronous to `clk`.
- `do`, out, `CH_NUM`: delayed channel outputs, registered.
- `ldcnt`, in, `CH_NUM`: per-channel tap load level from GPIO, asynchronous.
- `dicnt`, in, `CH_NUM*TAP_WIDTH`: tap values; channel k at `[k*TAP_WIDTH +: TAP_WIDTH]`, quasi-static.
- `docnt`, out, `CH_NUM*TAP_WIDTH`: current tap per channel, same packing.
- `sweep_en`, in, 1: sweep enable level from GPIO, asynchronous.
- `sweep_wrap`, out, 1: one-cycle pulse when channel 0 tap wraps `DEPTH-1`→0 in sweep.
- `rdy`, out, 1: delay lines flushed, outputs valid.

## Operation

- Reset (`rst`=0): all shift stages, taps, `do`, `docnt`, `sweep_wrap`, `rdy`, synchronisers, divider → 0; init FSM → INIT.
- Shift register per channel: stage 0 ← `di[k]` every cycle; stage i ← stage i-1. `do[k]` ← stage `tap[k]` (registered), giving total delay `tap[k]+1` cycles from `di` to `do`.
- Init FSM: INIT counts `DEPTH` cycles after reset release → READY (`rdy`=1, stays until reset). While INIT, `do` forced 0.
- `ldcnt[k]` and `sweep_en` pass through 2-FF synchronisers. A rising edge on synchronised `ldcnt[k]` (registered previous value vs current) loads `tap[k]` ← `dicnt` field k. Falling edges and held levels do nothing. Loads are accepted in INIT and READY.
- Sweep FSM: IDLE → RUN when synchronised `sweep_en`=1 and `rdy`=1; RUN → IDLE when synchronised `sweep_en`=0 (divider cleared to 0 on entry to IDLE). In RUN, the divider counts 0..`SWEEP_DIV-1`; at terminal count, every tap increments modulo `DEPTH` (`DEPTH-1`→0 wraps), and `sweep_wrap` pulses if channel 0 wrapped.
- Simultaneous load edge and sweep step on channel k: load wins for k; other channels still step. If channel 0 is loaded that cycle, `sweep_wrap` stays 0.
- Tap change takes effect immediately on the output mux. Bits may be repeated or dropped once at the switch; no glitch suppression.
- `docnt` mirrors tap registers directly (no extra latency).
- Reset mid-sweep or mid-load: immediate return to reset values; sweep resumes only after `rdy` and synchronised `sweep_en`.

## Timing

- `di`→`do`: `tap+1` cycles (tap 0 → 1 cycle, tap `DEPTH-1` → `DEPTH` cycles).
- `ldcnt` first sampled high at edge n: tap and `docnt` updated after edge n+3. `dicnt` stable from n-1 to n+4.
- New tap visible on `do` from edge n+4.
- `rdy` rises after edge `DEPTH` counted from first edge with `rst`=1.
- `sweep_en` high sampled at edge n (with `rdy`=1): RUN from n+2; first step at n+2+`SWEEP_DIV`, then every `SWEEP_DIV` cycles.
- `sweep_wrap` asserted the same cycle as the wrapped `docnt` value.

## Test plan

- Reset/init, `CH_NUM`=4, `TAP_WIDTH`=5: hold `rst`=0, drive `di`=4'hF → `do`=0, `docnt`=0, `rdy`=0; release → `rdy`=1 exactly 32 cycles later, `do` 0 until then.
- Delay accuracy: load ch1 tap 7, pulse on `di[1]` → `do[1]` pulse 8 cycles later; tap 0 → 1 cycle; tap 31 → 32 cycles; other channels unaffected.
- Load edge semantics: hold `ldcnt[2]`=1 while changing `dicnt` ch2 10→20 → tap stays 10; toggle 0→1 → tap 20, `docnt` updated 3 cycles after first high sample.
- Sweep with `SWEEP_DIV`=4: all taps 30, enable → taps 31 then 0 at 4-cycle spacing; `sweep_wrap` single pulse on the 31→0 step; disable → taps frozen, divider cleared.
- Collision: ch0 load edge (value 5) on a sweep step cycle → ch0 tap 5, no `sweep_wrap`, ch1..3 incremented.
- Reset mid-sweep: assert `rst` during RUN → all outputs 0 immediately; after release with `sweep_en` held high, stepping resumes only after `rdy`+2+`SWEEP_DIV` cycles.
